// File: rtl/multicycle_op_sequencer.sv
// Execute-stage sequencer for multi-beat ALU opcodes: stalls upstream, counts beats
// and holds the opcodes steady for the ALU until the operation completes.
module multicycle_op_sequencer #(
  parameter int unsigned           OP_WIDTH   = 5,
  parameter int unsigned           CNT_WIDTH  = 3,
  parameter logic [OP_WIDTH-1:0]   MC_OP_A    = 5'b01000,
  parameter int unsigned           MC_BEATS_A = 4,
  parameter logic [OP_WIDTH-1:0]   MC_OP_B    = 5'b01001,
  parameter int unsigned           MC_BEATS_B = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OP_WIDTH-1:0]  controlInOpA,
  input  logic [OP_WIDTH-1:0]  controlInOpB,
  input  logic                 flush,
  input  logic                 stall,
  output logic [OP_WIDTH-1:0]  controlOutOpA,
  output logic [OP_WIDTH-1:0]  controlOutOpB,
  output logic                 controlOutStall,
  output logic [CNT_WIDTH-1:0] controlOutCycleCnt,
  output logic                 busy,
  output logic                 lastBeat
);

  // One extra bit so a beat total of 2^CNT_WIDTH is representable.
  localparam int unsigned NW = CNT_WIDTH + 1;
  localparam logic [NW-1:0] N_A = NW'(MC_BEATS_A);
  localparam logic [NW-1:0] N_B = NW'(MC_BEATS_B);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [OP_WIDTH-1:0]  opa_q, opa_d, opb_q, opb_d;
  logic [NW-1:0]        n_q, n_d;

  logic          match_a, match_b, match;
  logic [NW-1:0] n_sel;
  logic          last;

  assign match_a = (controlInOpA == MC_OP_A);
  assign match_b = (controlInOpA == MC_OP_B);
  assign match   = match_a | match_b;
  assign n_sel   = match_a ? N_A : N_B;
  assign last    = ({1'b0, cnt_q} == (n_q - NW'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      n_q     <= n_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    cnt_d              = cnt_q;
    opa_d              = opa_q;
    opb_d              = opb_q;
    n_d                = n_q;
    controlOutOpA      = controlInOpA;
    controlOutOpB      = controlInOpB;
    controlOutStall    = 1'b0;
    controlOutCycleCnt = '0;
    busy               = 1'b0;
    lastBeat           = 1'b0;

    case (state_q)
      IDLE: begin
        if (match && !flush) begin
          if (n_sel > NW'(1)) begin
            // Beat 0 runs in the entry cycle; an external stall simply retries it.
            controlOutStall = 1'b1;
            if (!stall) begin
              state_d = RUN;
              cnt_d   = CNT_WIDTH'(1);
              opa_d   = controlInOpA;
              opb_d   = controlInOpB;
              n_d     = n_sel;
            end
          end else begin
            lastBeat = 1'b1;
          end
        end
      end

      RUN: begin
        controlOutOpA      = opa_q;
        controlOutOpB      = opb_q;
        controlOutCycleCnt = cnt_q;
        busy               = 1'b1;
        lastBeat           = last;
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
          opa_d   = '0;
          opb_d   = '0;
          n_d     = '0;
        end else begin
          controlOutStall = !last || stall;
          if (!stall) begin
            if (last) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_WIDTH'(1);
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: doc/multicycle_op_sequencer.md
Name: multicycle_op_sequencer

Overview:
- Execute-stage sequencer for multi-beat ALU opcodes. Generalises the single-opcode, fixed-4-cycle accumulate controller.
- Supports two programmable multi-cycle opcodes, each with its own beat count, and parametrised opcode and counter widths.
- Outputs a pipeline stall, a beat counter for ALU operand selection, and held opcodes for the duration of the operation.
- Sits between the ID/EX register and the ALU; the stall feeds the hazard unit.

Parameters:
- OP_WIDTH, 5, opcode field width.
- CNT_WIDTH, 3, beat counter width.
- MC_OP_A, 5'b01000, first multi-cycle opcode (AccumBytes).
- MC_BEATS_A, 4, total beats for MC_OP_A; legal range 1..2^CNT_WIDTH.
- MC_OP_B, 5'b01001, second multi-cycle opcode.
- MC_BEATS_B, 2, total beats for MC_OP_B; legal range 1..2^CNT_WIDTH.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- controlInOpA  in  OP_WIDTH  opcode A from ID/EX.
- controlInOpB  in  OP_WIDTH  opcode B from ID/EX.
- flush  in  1  pipeline flush.
- stall  in  1  external (downstream/memory) stall.
- controlOutOpA  out  OP_WIDTH  opcode A presented to the ALU.
- controlOutOpB  out  OP_WIDTH  opcode B presented to the ALU.
- controlOutStall  out  1  request to hold IF/ID/EX.
- controlOutCycleCnt  out  CNT_WIDTH  current beat index, 0-based.
- busy  out  1  high while in RUN.
- lastBeat  out  1  high on the final beat of a multi-cycle op.

Behaviour:
- Match: matchA = (controlInOpA==MC_OP_A); matchB = (controlInOpA==MC_OP_B). matchA has priority if both parameters are equal. Selected beat total is N.
- States are IDLE and RUN. Registered state: state, cnt, latchedOpA, latchedOpB, latchedN.
- Reset (asynchronous, any time including mid-op): state=IDLE, cnt=0, latches=0. Outputs become busy=0, lastBeat=0, controlOutCycleCnt=0, controlOutStall=0 unless a match is present combinationally, and opcodes pass through.

IDLE:
- Opcode outputs pass through controlInOpA/B; controlOutCycleCnt = 0.
- Match with N>1, ~flush: this cycle is beat 0 and controlOutStall=1 combinationally.
  - If ~stall: go to RUN, cnt<=1, latch controlInOpA, controlInOpB and N.
  - If stall: remain IDLE and re-evaluate next cycle.
- Match with N==1: single-cycle op. controlOutStall=0, lastBeat=1, no state change.
- flush=1: no entry; controlOutStall=0.

RUN:
- controlOutOpA = latchedOpA and controlOutOpB = latchedOpB, independent of the inputs.
- controlOutCycleCnt = cnt; busy=1.
- lastBeat = (cnt==latchedN-1).
- controlOutStall = ~lastBeat | stall. Upstream is held through the final beat while the external stall is active.
- stall=1: hold cnt and state, with no increment.
- flush=1 (priority over stall): abort to IDLE, cnt<=0, latches cleared. controlOutStall is 0 in the flush cycle.
- ~stall, ~lastBeat: cnt<=cnt+1.
- ~stall, lastBeat: go to IDLE, cnt<=0. The next instruction may match in the following cycle, giving back-to-back ops with no bubble.

Timing and arithmetic:
- Latency: an N-beat op occupies exactly N cycles in EX with no stall, or N plus the number of stall-held cycles otherwise.
- The counter never wraps. latchedN-1 fits in CNT_WIDTH because N≤2^CNT_WIDTH.
- Inputs seen during RUN are ignored; the stalled ID/EX register must re-present them afterwards.

Test Plan:
- Reset, then controlInOpA=01000, no stall → cnt 0,1,2,3; controlOutStall 1,1,1,0; lastBeat only at cnt=3; back to IDLE on cycle 5.
- controlInOpA=01001 → 2 beats: cnt 0,1; controlOutStall 1,0; controlOutOpB held at the latched value even when the input changes to 00011 in beat 1.
- AccumBytes with stall=1 during cnt=2 for 3 cycles, then stall=1 at cnt=3 for 1 cycle → cnt holds at 2 for 3 cycles; controlOutStall stays 1 through the stalled last beat; 8 cycles total.
- flush=1 at cnt=1 of AccumBytes → next cycle IDLE, cnt=0, busy=0; controlOutStall=0 in the flush cycle.
- rst asserted asynchronously mid-cycle at cnt=2 → cnt=0 and busy=0 immediately, without waiting for a clock edge; opcodes pass through.
- Two AccumBytes back to back → cnt 0,1,2,3,0,1,2,3 with no idle cycle; MC_BEATS_B=1 instance → 01001 gives controlOutStall=0, lastBeat=1.
